// File: rtl/btn_step_debounce.sv
// rtl/btn_step_debounce.sv - synchronize and debounce a raw pushbutton into clean press/release strobes
module btn_step_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_cnt
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHECK,
    PRESSED,
    RELEASE_CHECK
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   press_evt;
  logic                   release_evt;

  // Chain resets to the idle raw level so reset release never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state)
      RELEASED: begin
        if (sync) begin
          state_nxt = PRESS_CHECK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHECK: begin
        if (!sync) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_evt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_nxt = RELEASE_CHECK;
          cnt_nxt   = '0;
        end
      end
      RELEASE_CHECK: begin
        if (sync) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = RELEASED;
          cnt_nxt     = '0;
          release_evt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they change on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RELEASED;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_cnt     <= 8'h00;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      btn_level     <= (state_nxt == PRESSED) || (state_nxt == RELEASE_CHECK);
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if (press_evt) begin
        press_cnt <= press_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_btn_step_debounce.sv
// tb/tb_btn_step_debounce.sv - randomized and directed bench for btn_step_debounce against a run-length model
module tb_btn_step_debounce;

  logic       clk;
  logic       rst;
  logic [2:0] btn;
  logic [2:0] lvl;
  logic [2:0] pp;
  logic [2:0] rp;
  logic [7:0] pc [3];

  btn_step_debounce #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .btn_in(btn[0]), .btn_level(lvl[0]),
    .press_pulse(pp[0]), .release_pulse(rp[0]), .press_cnt(pc[0]));
  btn_step_debounce #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(3), .ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst(rst), .btn_in(btn[1]), .btn_level(lvl[1]),
    .press_pulse(pp[1]), .release_pulse(rp[1]), .press_cnt(pc[1]));
  btn_step_debounce #(.DEBOUNCE_CYCLES(1), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)) u2 (
    .clk(clk), .rst(rst), .btn_in(btn[2]), .btn_level(lvl[2]),
    .press_pulse(pp[2]), .release_pulse(rp[2]), .press_cnt(pc[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a level is accepted once D+1 consecutive synchronized samples agree with it.
  int   m_d  [3] = '{4, 4, 1};
  int   m_s  [3] = '{2, 3, 2};
  bit   m_al [3] = '{1'b0, 1'b1, 1'b0};
  bit   hist [3][$];
  bit   last_s [3];
  int   run  [3];
  bit   acc  [3];
  bit   e_press [3];
  bit   e_rel [3];
  logic [7:0] e_cnt [3];

  int n_vec = 0;
  int n_err = 0;
  int cc = 0;
  int np [3];
  int nr [3];
  int lastp [3];
  int lastr [3];
  int rl [3];
  int base;
  int p0;
  int r0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i].delete();
      for (int j = 0; j < m_s[i]; j++) hist[i].push_back(1'b0);
      last_s[i]  = 1'b0;
      run[i]     = 0;
      acc[i]     = 1'b0;
      e_press[i] = 1'b0;
      e_rel[i]   = 1'b0;
      e_cnt[i]   = 8'h00;
    end
  endtask

  task automatic model_step();
    bit s;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        s = hist[i].pop_front();
        hist[i].push_back(btn[i] ^ m_al[i]);
        run[i]     = (s == last_s[i]) ? run[i] + 1 : 1;
        last_s[i]  = s;
        e_press[i] = 1'b0;
        e_rel[i]   = 1'b0;
        if (run[i] >= m_d[i] + 1 && s != acc[i]) begin
          acc[i] = s;
          if (s) begin
            e_press[i] = 1'b1;
            e_cnt[i]   = e_cnt[i] + 8'd1;
          end else begin
            e_rel[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.btn_level", i), 32'(lvl[i]), 32'(acc[i]));
      chk($sformatf("u%0d.press_pulse", i), 32'(pp[i]), 32'(e_press[i]));
      chk($sformatf("u%0d.release_pulse", i), 32'(rp[i]), 32'(e_rel[i]));
      chk($sformatf("u%0d.press_cnt", i), 32'(pc[i]), 32'(e_cnt[i]));
      chk($sformatf("u%0d.pulse_overlap", i), 32'(pp[i] & rp[i]), 32'd0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cc++;
    for (int i = 0; i < 3; i++) begin
      if (pp[i] === 1'b1) begin np[i]++; lastp[i] = cc; end
      if (rp[i] === 1'b1) begin nr[i]++; lastr[i] = cc; end
    end
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      np[i] = 0; nr[i] = 0; lastp[i] = 0; lastr[i] = 0; rl[i] = 0;
    end
    model_reset();
    rst = 1'b1;
    btn = 3'b010;
    cyc();
    cyc();
    chk("reset.press_cnt", 32'(pc[0]), 32'h00);
    chk("reset.btn_level", 32'(lvl), 32'd0);
    rst = 1'b0;
    repeat (4) cyc();

    // Clean press: pulse in the cycle after edge k+2+4.
    btn[0] = 1'b1;
    base = cc;
    p0 = np[0];
    repeat (10) cyc();
    chk("press_latency", 32'(lastp[0] - base), 32'd7);
    chk("press_once", 32'(np[0] - p0), 32'd1);
    chk("press_cnt_1", 32'(pc[0]), 32'h01);
    btn[0] = 1'b0;
    repeat (10) cyc();

    // Three-cycle glitch must be rejected.
    p0 = np[0];
    btn[0] = 1'b1;
    repeat (3) cyc();
    btn[0] = 1'b0;
    repeat (10) cyc();
    chk("glitch_no_pulse", 32'(np[0] - p0), 32'd0);
    chk("glitch_cnt", 32'(pc[0]), 32'h01);

    // Release with a two-cycle high glitch mid-interval.
    btn[0] = 1'b1;
    repeat (10) cyc();
    r0 = nr[0];
    base = cc;
    btn[0] = 1'b0;
    repeat (2) cyc();
    btn[0] = 1'b1;
    repeat (2) cyc();
    btn[0] = 1'b0;
    repeat (12) cyc();
    chk("release_glitch_latency", 32'(lastr[0] - base), 32'd11);
    chk("release_glitch_once", 32'(nr[0] - r0), 32'd1);

    // 260 clean presses from reset: counter wraps to 4.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    p0 = np[0];
    r0 = nr[0];
    repeat (260) begin
      btn[0] = 1'b1;
      repeat (9) cyc();
      btn[0] = 1'b0;
      repeat (9) cyc();
    end
    chk("wrap_press_cnt", 32'(pc[0]), 32'h04);
    chk("wrap_press_count", 32'(np[0] - p0), 32'd260);
    chk("wrap_release_count", 32'(nr[0] - r0), 32'd260);

    // Randomized bouncy stimulus on all instances.
    repeat (2000) begin
      for (int i = 0; i < 3; i++) begin
        if (rl[i] == 0) begin
          btn[i] = 1'($urandom_range(0, 1));
          rl[i]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 14)) : int'($urandom_range(1, 4));
        end else begin
          rl[i]--;
        end
      end
      cyc();
    end
    btn = 3'b010;
    repeat (15) cyc();

    // Active-low instance: reset with idle-high input gives no pulses.
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    p0 = np[1];
    r0 = nr[1];
    repeat (10) cyc();
    chk("al_idle_press", 32'(np[1] - p0), 32'd0);
    chk("al_idle_release", 32'(nr[1] - r0), 32'd0);
    btn[1] = 1'b0;
    base = cc;
    repeat (12) cyc();
    chk("al_press_latency", 32'(lastp[1] - base), 32'd8);
    chk("al_press_once", 32'(np[1] - p0), 32'd1);
    btn[1] = 1'b1;
    repeat (12) cyc();

    // Single-sample debounce: held 50 cycles, one pulse after edge k+3.
    btn[2] = 1'b1;
    base = cc;
    p0 = np[2];
    r0 = nr[2];
    repeat (50) cyc();
    chk("d1_latency", 32'(lastp[2] - base), 32'd4);
    chk("d1_once", 32'(np[2] - p0), 32'd1);
    btn[2] = 1'b0;
    repeat (6) cyc();
    chk("d1_release", 32'(nr[2] - r0), 32'd1);

    // Asynchronous reset while held, then re-debounce after release of reset.
    btn[0] = 1'b1;
    repeat (10) cyc();
    chk("held_level", 32'(lvl[0]), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_level", 32'(lvl[0]), 32'd0);
    chk("async_rst_cnt", 32'(pc[0]), 32'h00);
    check_all();
    cyc();
    rst = 1'b0;
    base = cc;
    p0 = np[0];
    repeat (10) cyc();
    chk("rst_held_latency", 32'(lastp[0] - base), 32'd7);
    chk("rst_held_once", 32'(np[0] - p0), 32'd1);
    chk("rst_held_cnt", 32'(pc[0]), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_step_debounce.md
Name: btn_step_debounce

Overview:
- Conditions a raw, bouncy pushbutton into clean, single-cycle step strobes on the system clock.
- Sits directly upstream of the 8-bit LFSR / hex display stage. Its press_pulse is that stage's advance enable, replacing direct use of the button as a clock.
- Also provides the debounced level and a wrapping press counter for display and debug.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive stable synchronized samples required to accept a level change; legal range 1..65535.
- SYNC_STAGES, 2: depth of the input synchronizer flop chain; legal range 2..4.
- ACTIVE_LOW, 0: 1 = raw button reads 0 when pressed; the input is inverted after synchronization.

Ports:
- clk  input  1  system clock; all state in this block uses this clock.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw, asynchronous, bouncy button level.
- btn_level  output  1  debounced pressed level; 1 = pressed.
- press_pulse  output  1  one-cycle strobe on each accepted press.
- release_pulse  output  1  one-cycle strobe on each accepted release.
- press_cnt  output  8  count of accepted presses, modulo 256.

Behaviour:
- Reset (asynchronous, active-high):
  - Synchronizer flops load the inactive raw level: 0, or 1 when ACTIVE_LOW=1.
  - FSM goes to RELEASED; debounce counter = 0.
  - btn_level = 0, press_pulse = 0, release_pulse = 0, press_cnt = 8'h00.
- Synchronizer: SYNC_STAGES flops in series. sync = last stage, XORed with ACTIVE_LOW. No logic other than that XOR may read btn_in before the last stage.
- Debounce counter: width clog2(DEBOUNCE_CYCLES)+1. Clears on every FSM transition; otherwise increments by 1 while in a CHECK state.
- FSM states and transitions, evaluated at each clk edge:
  - RELEASED: sync=1 -> PRESS_CHECK, cnt=0. Otherwise stay.
  - PRESS_CHECK: sync=0 -> RELEASED (bounce rejected, no pulse). sync=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED. Otherwise cnt+1.
  - PRESSED: sync=0 -> RELEASE_CHECK, cnt=0. Otherwise stay.
  - RELEASE_CHECK: sync=1 -> PRESSED (bounce rejected, no pulse). sync=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED. Otherwise cnt+1.
- Outputs are all registered:
  - btn_level = 1 exactly in PRESSED and RELEASE_CHECK.
  - press_pulse = 1 for exactly the one cycle following the PRESS_CHECK->PRESSED edge.
  - release_pulse = 1 for exactly the one cycle following the RELEASE_CHECK->RELEASED edge.
  - press_pulse and release_pulse are never high in the same cycle.
- Latency: btn_in becomes active and stable before edge k, then press_pulse is high in the cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES; btn_level rises on that same edge. Release latency is symmetric.
- DEBOUNCE_CYCLES=1: a single sample in the CHECK state is enough. Transition happens on the edge after the CHECK state is entered.
- press_cnt: increments on the same edge that raises press_pulse; 8'hFF wraps to 8'h00; no saturation.
- Held button: exactly one press_pulse per press, no auto-repeat.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES sampled cycles produces no pulse and no btn_level change. A glitch during PRESSED does not deassert btn_level.
- Reset mid-operation: outputs clear immediately. If the button is still held when rst deasserts, a full new debounce interval elapses and then one press_pulse fires.

Test Plan:
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2: drive btn_in 0->1 before edge 10 and hold -> press_pulse high only in the cycle after edge 16; btn_level=1 from edge 16; press_cnt=1.
- Same configuration: btn_in high for 3 cycles, then low -> no press_pulse, btn_level stays 0, press_cnt=0. Then release a held button with a 2-cycle high glitch mid-interval -> release_pulse only after 4 consecutive low samples.
- 260 clean press/release cycles -> press_cnt reads 8'h04; exactly 260 press_pulse and 260 release_pulse strobes, never coincident.
- ACTIVE_LOW=1, btn_in idles high: assert and release rst -> no spurious pulse. Drive btn_in low and hold -> one press_pulse after SYNC_STAGES+DEBOUNCE_CYCLES edges.
- Button held in PRESSED, assert rst asynchronously mid-cycle -> all outputs 0 before the next edge. Deassert rst with the button still held -> exactly one press_pulse, 2+4 edges later; press_cnt=1.
- DEBOUNCE_CYCLES=1: single-edge press -> press_pulse in the cycle after edge k+3; button held 50 cycles -> exactly one pulse.
